uvma_st_if_proto_chkr: RTL

//  Parametrised, synthesizable protocol checker for NUM_CH valid/ready streams on the st agent interface.

---
 rtl/uvma_st_chkr_pkg.sv | 28 ++
 rtl/uvma_st_if_proto_chkr_if.sv | 18 +
 rtl/uvma_st_chkr_chan.sv | 125 ++++++++++++
 rtl/uvma_st_if_proto_chkr.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uvma_st_chkr_pkg.sv
// Shared types for the st-interface protocol checker.
//   err_code_e   : per-channel error code, lowest value wins on coincidence
//   chkr_state_e : per-channel handshake FSM state
//   stall_cnt_w  : width of a stall counter that must reach TIMEOUT
package uvma_st_chkr_pkg;

    localparam int unsigned ERR_CODE_W = 3;

    // ErrXOnCtrl is reserved for simulation-only X checks; the synthesizable
    // checker never produces it.
    typedef enum logic [ERR_CODE_W-1:0] {
        ErrNone      = 3'd0,
        ErrValidDrop = 3'd1,
        ErrDataChg   = 3'd2,
        ErrStall     = 3'd3,
        ErrXOnCtrl   = 3'd4
    } err_code_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } chkr_state_e;

    function automatic int unsigned stall_cnt_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/uvma_st_if_proto_chkr_if.sv
// Bundle of NUM_CH valid/ready/data streams.
//   master : drives valid/data, observes ready
//   slave  : observes valid/data, drives ready
//   mon    : passive view used by the protocol checker
interface uvma_st_if_proto_chkr_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32
) ();

    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH-1:0]        ready;
    logic [NUM_CH*DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
    modport mon    (input valid, input ready, input data);

endinterface

// File: rtl/uvma_st_chkr_chan.sv
// Single-channel handshake checker: IDLE/WAIT FSM, stall counter, data capture
// and a registered error encoder.
//   clk, reset      : clock, async active-high reset
//   enable          : 0 forces IDLE and suppresses checking
//   clear           : drops the violations detected this cycle
//   valid/ready/data: the observed stream
//   code            : registered lowest error code of the previous cycle
//   n_viol          : registered number of violations of the previous cycle (0..2)
//   stall_cnt, xfer : stats taps, present only with UVMA_ST_CHKR_STATS_EN
module uvma_st_chkr_chan
    import uvma_st_chkr_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = stall_cnt_w(TIMEOUT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output err_code_e         code,
    output logic [1:0]        n_viol
`ifdef UVMA_ST_CHKR_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              xfer
`endif
);

    chkr_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] cap_q, cap_d;
    err_code_e         code_q, code_d;
    logic [1:0]        n_viol_q, n_viol_d;
    logic              drop, chg, stall;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        drop    = 1'b0;
        chg     = 1'b0;
        stall   = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid && !ready) begin
                        state_d = StWait;
                        cap_d   = data;
                        cnt_d   = CNT_W'(1);
                    end
                end
                StWait: begin
                    if (!valid) begin
                        drop    = 1'b1;
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        // Data is compared before ready, so a changed beat that
                        // is accepted still counts as a violation.
                        chg = (data != cap_q);
                        if (ready) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else if (cnt_q < CNT_W'(TIMEOUT)) begin
                            cnt_d = cnt_inc;
                            // Counter saturates at TIMEOUT, so this edge fires
                            // only once per stall episode.
                            stall = (cnt_inc == CNT_W'(TIMEOUT));
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        code_d   = ErrNone;
        n_viol_d = '0;
        if (!clear) begin
            if (drop) begin
                code_d = ErrValidDrop;
            end else if (chg) begin
                code_d = ErrDataChg;
            end else if (stall) begin
                code_d = ErrStall;
            end
            n_viol_d = {1'b0, drop} + {1'b0, chg} + {1'b0, stall};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            cap_q    <= '0;
            code_q   <= ErrNone;
            n_viol_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            code_q   <= code_d;
            n_viol_q <= n_viol_d;
        end
    end

    assign code   = code_q;
    assign n_viol = n_viol_q;

`ifdef UVMA_ST_CHKR_STATS_EN
    assign stall_cnt = cnt_q;
    assign xfer      = enable & valid & ready;
`endif

endmodule

// File: rtl/uvma_st_if_proto_chkr.sv
// Passive protocol checker for NUM_CH valid/ready streams.
//   clk, reset : clock, async active-high reset
//   enable     : 0 suspends checking (channel FSMs idle, flags held)
//   clear      : 1-cycle pulse clearing flags, codes and err_cnt (wins over new errors)
//   st_if      : monitored streams (mon modport)
//   err        : sticky per-channel error flag
//   err_code   : first error code per channel, 3 bits each
//   err_cnt    : saturating count of all violations
//   err_pulse  : one-cycle flag for any new violation
// Optional macro UVMA_ST_CHKR_STATS_EN adds xfer_cnt (32-bit wrapping transfer
// counters) and max_stall (longest WAIT seen) per channel.
module uvma_st_if_proto_chkr
    import uvma_st_chkr_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 256,
    parameter int unsigned ERR_CNT_W = 16,
    localparam int unsigned CNT_W    = stall_cnt_w(TIMEOUT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    uvma_st_if_proto_chkr_if.mon         st_if,
    output logic [NUM_CH-1:0]            err,
    output logic [NUM_CH*ERR_CODE_W-1:0] err_code,
    output logic [ERR_CNT_W-1:0]         err_cnt,
    output logic                         err_pulse
`ifdef UVMA_ST_CHKR_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]         xfer_cnt,
    output logic [NUM_CH*CNT_W-1:0]      max_stall
`endif
);

    localparam int unsigned SUM_W = $clog2(2 * NUM_CH + 1);
    localparam int unsigned ACC_W = ((ERR_CNT_W > SUM_W) ? ERR_CNT_W : SUM_W) + 1;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    err_code_e  chan_code  [NUM_CH];
    logic [1:0] chan_nviol [NUM_CH];
`ifdef UVMA_ST_CHKR_STATS_EN
    logic [CNT_W-1:0]  chan_stall [NUM_CH];
    logic [NUM_CH-1:0] chan_xfer;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        uvma_st_chkr_chan #(
            .DATA_W  (DATA_W),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .clear     (clear),
            .valid     (st_if.valid[i]),
            .ready     (st_if.ready[i]),
            .data      (st_if.data[i*DATA_W +: DATA_W]),
            .code      (chan_code[i]),
            .n_viol    (chan_nviol[i])
`ifdef UVMA_ST_CHKR_STATS_EN
            ,
            .stall_cnt (chan_stall[i]),
            .xfer      (chan_xfer[i])
`endif
        );
    end

    logic [NUM_CH-1:0]                 err_q, err_d;
    logic [NUM_CH-1:0][ERR_CODE_W-1:0] err_code_q, err_code_d;
    logic [ERR_CNT_W-1:0]              err_cnt_q, err_cnt_d;
    logic                              err_pulse_q, err_pulse_d;
    logic [SUM_W-1:0]                  viol_sum;
    logic [ACC_W-1:0]                  acc;

    always_comb begin
        viol_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            viol_sum = viol_sum + SUM_W'(chan_nviol[i]);
        end
        acc = ACC_W'(err_cnt_q) + ACC_W'(viol_sum);

        err_d       = err_q;
        err_code_d  = err_code_q;
        err_cnt_d   = (acc > ACC_W'(CNT_MAX)) ? CNT_MAX : acc[ERR_CNT_W-1:0];
        err_pulse_d = (viol_sum != '0);
        for (int i = 0; i < NUM_CH; i++) begin
            if (chan_nviol[i] != 2'd0) begin
                err_d[i] = 1'b1;
                // Only the first violation of a channel is recorded.
                if (!err_q[i]) begin
                    err_code_d[i] = chan_code[i];
                end
            end
        end
        if (clear) begin
            err_d       = '0;
            err_code_d  = '0;
            err_cnt_d   = '0;
            err_pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q       <= '0;
            err_code_q  <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
    assign err_pulse = err_pulse_q;

`ifdef UVMA_ST_CHKR_STATS_EN
    logic [NUM_CH-1:0][31:0]      xfer_cnt_q, xfer_cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] max_stall_q, max_stall_d;

    always_comb begin
        xfer_cnt_d  = xfer_cnt_q;
        max_stall_d = max_stall_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chan_xfer[i]) begin
                xfer_cnt_d[i] = xfer_cnt_q[i] + 32'd1;
            end
            if (chan_stall[i] > max_stall_q[i]) begin
                max_stall_d[i] = chan_stall[i];
            end
        end
        if (clear) begin
            xfer_cnt_d  = '0;
            max_stall_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt_q  <= '0;
            max_stall_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            max_stall_q <= max_stall_d;
        end
    end

    assign xfer_cnt  = xfer_cnt_q;
    assign max_stall = max_stall_q;
`endif

endmodule
